light_link_arbiter: RTL

Round-robin arbiter that shares one lamp control link between N switch requesters. Each requester raises a request carrying the lamp state it wants; the arbiter grants one requester at a time, applies its command to the link's `on_off` signal, and holds that state for a guaranteed minimum time before re-arbitrating. It sits between the switch modules and the bulb, replacing direct switch-to-bulb wiring when several switches control one lamp.

---
 rtl/light_link_arbiter_pkg.sv | 17 +
 rtl/light_link_arbiter_if.sv | 17 +
 rtl/light_link_arbiter_rr_pick.sv | 32 +++
 rtl/light_link_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/light_link_arbiter_pkg.sv
// Shared types for the lamp-link arbiter: state encoding and round-robin step helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package light_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_APPLY = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_t;

    // Next candidate index after idx, wrapping at n.
    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/light_link_arbiter_if.sv
// Switch-side bundle of the lamp link: requests/commands in, grant/status out.
// Latency: none (wires only).
// Backpressure: a requester keeps req high until done; gnt is the only flow control.
interface light_link_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] cmd_on;
    logic [N_REQ-1:0] gnt;
    logic             done;
    logic             on_off;
    logic             busy;
    logic             auto_off;

    modport master (output req, cmd_on, input gnt, done, on_off, busy, auto_off);
    modport slave  (input req, cmd_on, output gnt, done, on_off, busy, auto_off);
endinterface

// File: rtl/light_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after last, wrapping.
// Latency: 0 cycles.
// Backpressure: none; vld low when no request is active.
module light_arb_rr_pick
    import light_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] win,
    output logic             vld
);
    int               idx;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win  = '0;
        vld  = 1'b0;
        idx  = int'(last);
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = rr_next_idx(idx, N_REQ);
            cand = IDX_W'(idx);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                win = cand;
            end
        end
    end
endmodule

// File: rtl/light_link_arbiter.sv
// Round-robin owner of the lamp on_off line; optional idle auto-off (LIGHT_LINK_ARB_AUTO_OFF_EN).
// Latency: gnt 1 cycle after req, on_off 2, done 2+HOLD_CYC; all outputs registered.
// Backpressure: losers wait unacknowledged until the next IDLE; dropping req mid-hold aborts.
module light_link_arbiter
    import light_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_CYC     = 4,
    parameter int AUTO_OFF_CYC = 16
) (
    input logic                  clk,
    input logic                  rst,
    light_link_arbiter_if.slave  lnk
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int HCW   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int ACW   = $clog2(AUTO_OFF_CYC + 1);

    if (N_REQ < 2 || HOLD_CYC < 1 || AUTO_OFF_CYC < 1) begin : g_param_check
        $error("light_link_arbiter: illegal parameter value");
    end

    arb_state_t       st, st_nxt;
    logic [N_REQ-1:0] gnt_q, gnt_nxt;
    logic [IDX_W-1:0] win_q, win_nxt, last_q, last_nxt, pick_idx;
    logic [HCW-1:0]   hold_q, hold_nxt;
    logic             done_q, done_nxt, on_q, on_nxt, auto_q, auto_nxt, pick_vld;
    logic [ACW-1:0]   idle_q, idle_nxt;

    light_arb_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req  (lnk.req),
        .last (last_q),
        .win  (pick_idx),
        .vld  (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ARB_IDLE;
            gnt_q  <= '0;
            win_q  <= '0;
            last_q <= IDX_W'(N_REQ - 1);
            hold_q <= '0;
            done_q <= 1'b0;
            on_q   <= 1'b0;
            auto_q <= 1'b0;
            idle_q <= '0;
        end else begin
            st     <= st_nxt;
            gnt_q  <= gnt_nxt;
            win_q  <= win_nxt;
            last_q <= last_nxt;
            hold_q <= hold_nxt;
            done_q <= done_nxt;
            on_q   <= on_nxt;
            auto_q <= auto_nxt;
            idle_q <= idle_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        gnt_nxt  = gnt_q;
        win_nxt  = win_q;
        last_nxt = last_q;
        hold_nxt = hold_q;
        done_nxt = 1'b0;
        on_nxt   = on_q;
        auto_nxt = 1'b0;
        idle_nxt = '0;
        case (st)
            ARB_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    win_nxt           = pick_idx;
                    st_nxt            = ARB_APPLY;
                end
            end
            ARB_APPLY: begin
                on_nxt   = lnk.cmd_on[win_q];
                hold_nxt = HCW'(HOLD_CYC - 1);
                st_nxt   = ARB_HOLD;
            end
            ARB_HOLD: begin
                // Abort takes priority over normal completion: no done pulse.
                if (!lnk.req[win_q]) begin
                    gnt_nxt  = '0;
                    last_nxt = win_q;
                    st_nxt   = ARB_IDLE;
                end else if (hold_q == '0) begin
                    done_nxt = 1'b1;
                    gnt_nxt  = '0;
                    last_nxt = win_q;
                    st_nxt   = ARB_IDLE;
                end else begin
                    hold_nxt = hold_q - HCW'(1);
                end
            end
            default: begin
                gnt_nxt = '0;
                st_nxt  = ARB_IDLE;
            end
        endcase
`ifdef LIGHT_LINK_ARB_AUTO_OFF_EN
        // A request on the timeout edge keeps req nonzero, so the grant wins.
        if (st == ARB_IDLE && on_q && lnk.req == '0) begin
            if (idle_q == ACW'(AUTO_OFF_CYC - 1)) begin
                on_nxt   = 1'b0;
                auto_nxt = 1'b1;
            end else begin
                idle_nxt = idle_q + ACW'(1);
            end
        end
`endif
    end

    assign lnk.gnt      = gnt_q;
    assign lnk.done     = done_q;
    assign lnk.on_off   = on_q;
    assign lnk.busy     = (st != ARB_IDLE);
    assign lnk.auto_off = auto_q;
endmodule
